cache_refill_ctrl: RTL and testbench
====================================

// Module: cache_refill_ctrl
// PURPOSE
//  Miss handler between the data Cache and DRAM in the memory stage.
//  - Read miss: fetches the whole 32-byte block (8 words) from DRAM, writes each word
//    into the cache data array, then writes tag and valid.
//  - Write miss (write-through, no-allocate): issues one DRAM word write.
//  - Cache holds freeze_cpu while refill_busy=1; completion is signalled by a 1-cycle refill_done.
// PARAMETERS
//  WORDS_PER_BLOCK  8   words per cache block (power of 2)
//  INDEX_BITS       7   cache index width (128 blocks)
//  TAG_BITS         20  tag width (32 - INDEX_BITS - 5)
// PORTS
//  clk            in   1           clock; all state changes on posedge
//  rst            in   1           synchronous, active-high reset
//  miss_req       in   1           Cache reports a miss; sampled only in IDLE
//  miss_is_write  in   1           1=store miss, 0=load miss
//  miss_addr      in   32          byte address of the missing access
//  miss_wdata     in   32          store data for a write miss
//  refill_busy    out  1           controller is not IDLE
//  refill_done    out  1           1-cycle pulse, transaction finished
//  fill_we        out  1           write fill_data into data[{fill_index,fill_word}]
//  fill_index     out  INDEX_BITS  block index being filled
//  fill_word      out  3           word within block
//  fill_data      out  32          word returned by DRAM
//  tag_we         out  1           write tag_value to tags[fill_index] and set valid
//  tag_value      out  TAG_BITS    tag of refilled block
//  dram_signal    out  2           0 IDLE, 1 READ, 2 WRITE
//  dram_addr      out  32          byte address to DRAM
//  dram_write_data out 32          DRAM write data
//  dram_ready     in   1           DRAM access complete (meaningful only while dram_signal!=0)
//  dram_result    in   32          DRAM read data, valid when dram_ready=1 and dram_signal=READ
// BEHAVIOUR
//  States: IDLE, RD, WR, DONE. Registered: state, word counter k, latched addr/wdata.
//  Reset (sync, rst wins over everything): state=IDLE, k=0; all outputs 0 in that cycle and
//    the next; any in-progress refill is abandoned, no tag_we or fill_we issued.
//  IDLE: busy=0, dram_signal=0. miss_req=1 -> latch miss_addr/miss_wdata/miss_is_write, k=0,
//    go to WR if miss_is_write else RD. refill_busy rises the cycle after miss_req.
//  RD: dram_signal=1, dram_addr={addr[31:5], k, 2'b00}. When dram_ready=1 in this cycle:
//    fill_we=1, fill_word=k, fill_data=dram_result, fill_index=addr[11:5];
//    if k==7 also tag_we=1, tag_value=addr[31:12], go DONE; else k<=k+1, stay RD.
//    dram_signal is held at 1 across words (no idle gap); address changes with k.
//  WR: dram_signal=2, dram_addr={addr[31:2],2'b00}, dram_write_data=latched wdata.
//    On dram_ready=1: go DONE. No fill_we or tag_we.
//  DONE: refill_done=1, dram_signal=0, busy=1; next cycle IDLE. miss_req ignored here.
//  Latency (DRAM LATENCY=L, L+1 cycles per word): read miss = 8*(L+1) cycles in RD, plus 1
//    in DONE; write miss = (L+1) + 1. With L=4: 41 and 6 cycles after leaving IDLE.
//  dram_ready=1 while dram_signal=0 (idle DRAM) is ignored.
//  miss_req while busy is ignored; the Cache must hold it until refill_done.
//  fill_*, tag_* and dram_addr are 0 when not driven as above.
//  k wraps only through the DONE transition; never exceeds 7.
// TESTING
//  1. rst=1 for 2 cycles -> all outputs 0, state IDLE; dram_ready=1 while idle -> no activity.
//  2. Load miss addr 0x0000_1044, L=4 -> DRAM reads 0x1040..0x105C in order;
//     8 fill_we at index 2, words 0..7; tag_we with tag 0x00001 on the 8th;
//     refill_done 41 cycles after accept.
//  3. Store miss addr 0x0000_0088, data 0xDEADBEEF -> one WRITE to 0x88 with that data;
//     no fill_we or tag_we; refill_done after 6 cycles.
//  4. miss_req pulsed again during RD and in DONE -> ignored; exactly one transaction completes.
//  5. rst asserted after 3rd word of a refill -> next cycle IDLE, dram_signal=0,
//     no tag_we ever; a new miss then refills from word 0.
//  6. Back-to-back: new miss_req on the cycle after refill_done (IDLE) -> accepted, correct new base.

Source files
------------

// File: rtl/cache_refill_ctrl.sv
// Data-cache miss handler: refills whole blocks from DRAM on load
// misses and forwards single-word writes on store misses.
module cache_refill_ctrl #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int INDEX_BITS      = 7,
  parameter int TAG_BITS        = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic                  miss_is_write,
  input  logic [31:0]           miss_addr,
  input  logic [31:0]           miss_wdata,
  output logic                  refill_busy,
  output logic                  refill_done,
  output logic                  fill_we,
  output logic [INDEX_BITS-1:0] fill_index,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [31:0]           fill_data,
  output logic                  tag_we,
  output logic [TAG_BITS-1:0]   tag_value,
  output logic [1:0]            dram_signal,
  output logic [31:0]           dram_addr,
  output logic [31:0]           dram_write_data,
  input  logic                  dram_ready,
  input  logic [31:0]           dram_result
);

  localparam int WB  = $clog2(WORDS_PER_BLOCK);
  localparam int OFF = WB + 2;
  localparam int BB  = 32 - OFF;

  localparam logic [1:0] SIG_IDLE  = 2'd0;
  localparam logic [1:0] SIG_READ  = 2'd1;
  localparam logic [1:0] SIG_WRITE = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t          state;
  logic [WB-1:0]   k;
  logic [BB-1:0]   base;
  logic            busy_q;
  logic            done_q;
  logic [1:0]      sig_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;

  logic            fill_hit;
  logic            last;
  logic [WB-1:0]   k_nxt;
  logic            unused_bits;

  assign last        = (k == WB'(WORDS_PER_BLOCK - 1));
  assign k_nxt       = k + WB'(1);
  assign unused_bits = ^miss_addr[1:0];

  // Fill strobes follow dram_ready in the same cycle; rst masks
  // everything so an abandoned refill never touches the arrays.
  assign fill_hit = !rst && (state == RD) && dram_ready;

  assign fill_we    = fill_hit;
  assign fill_index = fill_hit ? base[INDEX_BITS-1:0] : '0;
  assign fill_word  = fill_hit ? k : '0;
  assign fill_data  = fill_hit ? dram_result : '0;
  assign tag_we     = fill_hit && last;
  assign tag_value  = (fill_hit && last) ? base[BB-1 -: TAG_BITS] : '0;

  assign refill_busy     = !rst && busy_q;
  assign refill_done     = !rst && done_q;
  assign dram_signal     = rst ? SIG_IDLE : sig_q;
  assign dram_addr       = rst ? '0 : addr_q;
  assign dram_write_data = rst ? '0 : wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      k       <= '0;
      base    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sig_q   <= SIG_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (miss_req) begin
            base   <= miss_addr[31:OFF];
            k      <= '0;
            busy_q <= 1'b1;
            if (miss_is_write) begin
              state   <= WR;
              sig_q   <= SIG_WRITE;
              addr_q  <= {miss_addr[31:2], 2'b00};
              wdata_q <= miss_wdata;
            end else begin
              state  <= RD;
              sig_q  <= SIG_READ;
              addr_q <= {miss_addr[31:OFF], {OFF{1'b0}}};
            end
          end
        end
        RD: begin
          if (dram_ready) begin
            if (last) begin
              state  <= DONE;
              k      <= '0;
              sig_q  <= SIG_IDLE;
              addr_q <= '0;
              done_q <= 1'b1;
            end else begin
              k      <= k_nxt;
              addr_q <= {base, k_nxt, 2'b00};
            end
          end
        end
        WR: begin
          if (dram_ready) begin
            state   <= DONE;
            sig_q   <= SIG_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: stimulus pushes expected
// DRAM accesses, fills, tags and completion cycles; a monitor pops.
module tb_cache_refill_ctrl;

  localparam int L = 4;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic        miss_is_write;
  logic [31:0] miss_addr;
  logic [31:0] miss_wdata;
  logic        refill_busy;
  logic        refill_done;
  logic        fill_we;
  logic [6:0]  fill_index;
  logic [2:0]  fill_word;
  logic [31:0] fill_data;
  logic        tag_we;
  logic [19:0] tag_value;
  logic [1:0]  dram_signal;
  logic [31:0] dram_addr;
  logic [31:0] dram_write_data;
  logic        dram_ready;
  logic [31:0] dram_result;

  cache_refill_ctrl dut (
    .clk(clk),
    .rst(rst),
    .miss_req(miss_req),
    .miss_is_write(miss_is_write),
    .miss_addr(miss_addr),
    .miss_wdata(miss_wdata),
    .refill_busy(refill_busy),
    .refill_done(refill_done),
    .fill_we(fill_we),
    .fill_index(fill_index),
    .fill_word(fill_word),
    .fill_data(fill_data),
    .tag_we(tag_we),
    .tag_value(tag_value),
    .dram_signal(dram_signal),
    .dram_addr(dram_addr),
    .dram_write_data(dram_write_data),
    .dram_ready(dram_ready),
    .dram_result(dram_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int fill_cnt = 0;
  int cnt = 0;
  logic idle_ready = 1'b0;

  logic [41:0] fill_q[$];
  logic [19:0] tag_q[$];
  logic [31:0] rd_q[$];
  logic [63:0] wr_q[$];
  int          done_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic stray(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: unexpected event got %h expected none (cycle %0d)",
             name, act, cyc);
  endtask

  // DRAM: ready in the (L+1)th cycle of each access
  always @(posedge clk) begin
    #1;
    if (dram_signal == 2'd0) begin
      cnt = 0;
      dram_ready = idle_ready;
    end else if (cnt == L) begin
      dram_ready = 1'b1;
      cnt = 0;
    end else begin
      dram_ready = 1'b0;
      cnt++;
    end
    dram_result = (dram_signal == 2'd1 && dram_ready) ? (dram_addr ^ KEY) : 32'h0;
  end

  always @(negedge clk) begin
    if (fill_we) begin
      fill_cnt++;
      if (fill_q.size() == 0) stray("fill", {fill_index, fill_word, fill_data});
      else chk("fill", {fill_index, fill_word, fill_data}, fill_q.pop_front());
    end else begin
      chk("fill_idle", {fill_index, fill_word, fill_data}, 64'h0);
    end
    if (tag_we) begin
      if (tag_q.size() == 0) stray("tag", tag_value);
      else chk("tag", tag_value, tag_q.pop_front());
    end else begin
      chk("tag_idle", tag_value, 64'h0);
    end
    if (refill_done) begin
      done_cnt++;
      if (done_q.size() == 0) stray("done", cyc);
      else chk("done_cycle", cyc, done_q.pop_front());
    end
    if (dram_signal == 2'd1 && dram_ready) begin
      if (rd_q.size() == 0) stray("dram_rd", dram_addr);
      else chk("dram_rd", dram_addr, rd_q.pop_front());
    end
    if (dram_signal == 2'd2 && dram_ready) begin
      if (wr_q.size() == 0) stray("dram_wr", {dram_addr, dram_write_data});
      else chk("dram_wr", {dram_addr, dram_write_data}, wr_q.pop_front());
    end
    if (dram_signal == 2'd0) chk("dram_addr_idle", dram_addr, 64'h0);
  end

  task automatic issue(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input int nw);
    logic [31:0] ba;
    logic [2:0]  w3;
    @(negedge clk);
    miss_req = 1'b1;
    miss_is_write = wr;
    miss_addr = a;
    miss_wdata = d;
    if (wr) begin
      wr_q.push_back({a[31:2], 2'b00, d});
      done_q.push_back(cyc + 6);
    end else begin
      for (int w = 0; w < nw; w++) begin
        w3 = w[2:0];
        ba = {a[31:5], w3, 2'b00};
        rd_q.push_back(ba);
        fill_q.push_back({a[11:5], w3, ba ^ KEY});
      end
      if (nw == 8) begin
        tag_q.push_back(a[31:12]);
        done_q.push_back(cyc + 41);
      end
    end
    @(negedge clk);
    miss_req = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int s;
    s = done_cnt;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > s) return;
    end
    errors++;
    checks++;
    $display("FAIL wait_done: timeout got no refill_done expected one within %0d cycles", max);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, "_busy"}, refill_busy, 64'h0);
    chk({name, "_sig"}, dram_signal, 64'h0);
    chk({name, "_outs"}, {refill_done, fill_we, tag_we, dram_addr}, 64'h0);
  endtask

  initial begin
    int s;
    rst = 1'b1;
    miss_req = 1'b0;
    miss_is_write = 1'b0;
    miss_addr = '0;
    miss_wdata = '0;
    dram_ready = 1'b0;
    dram_result = '0;

    // 1: reset, then idle DRAM ready is ignored
    repeat (2) begin
      @(negedge clk);
      chk_quiet("reset");
    end
    rst = 1'b0;
    idle_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      chk_quiet("idle_ready");
    end
    idle_ready = 1'b0;

    // 2: load miss
    issue(1'b0, 32'h0000_1044, 32'h0, 8);
    chk("busy_rises", refill_busy, 64'h1);
    wait_done(60);

    // 3: store miss
    issue(1'b1, 32'h0000_0088, 32'hDEAD_BEEF, 0);
    wait_done(20);

    // 4: miss_req during RD and during DONE is ignored
    issue(1'b0, 32'h0000_2000, 32'h0, 8);
    repeat (7) @(negedge clk);
    miss_req = 1'b1;
    miss_addr = 32'h0000_3000;
    @(negedge clk);
    miss_req = 1'b0;
    wait_done(60);
    miss_req = 1'b1;
    miss_addr = 32'h0000_4000;
    @(negedge clk);
    miss_req = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk_quiet("after_ignore");

    // 5: reset in the middle of a refill
    s = fill_cnt;
    issue(1'b0, 32'h0001_23A0, 32'h0, 3);
    for (int i = 0; i < 40 && fill_cnt < s + 3; i++) @(negedge clk);
    chk("abort_fills", fill_cnt - s, 64'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_quiet("rst_cycle");
    @(negedge clk);
    chk_quiet("rst_next");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk_quiet("rst_after");
    issue(1'b0, 32'h0001_23A0, 32'h0, 8);
    wait_done(60);

    // 6: back-to-back misses right after refill_done
    issue(1'b1, 32'h0000_0F04, 32'h1234_5678, 0);
    wait_done(20);
    issue(1'b0, 32'h0003_FFE0, 32'h0, 8);
    wait_done(60);
    issue(1'b0, 32'hFFFF_F01C, 32'h0, 8);
    wait_done(60);

    repeat (4) @(negedge clk);
    chk("drain_fill", fill_q.size(), 64'h0);
    chk("drain_tag", tag_q.size(), 64'h0);
    chk("drain_rd", rd_q.size(), 64'h0);
    chk("drain_wr", wr_q.size(), 64'h0);
    chk("drain_done", done_q.size(), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
